// File: rtl/fp_sq_accum.sv
`default_nettype none
// ============================================================================
// Module   : fp_sq_accum (with helper fp_sq_accum_add)
// Purpose  : Sums a vector of FP squares into one sum-of-squares.
//            The adds are interleaved over ADD_STAGES lanes, which are then
//            reduced serially. FP_SQ_ACCUM_DROP_ERR_EN enables the sticky
//            drop_err flag.
// Revision : 1.0 - initial release
// ============================================================================

module fp_sq_accum_add #(
   parameter int SIG_WIDTH       = 23,
   parameter int EXP_WIDTH       = 8,
   parameter int IEEE_COMPLIANCE = 0
) (
   input  logic [SIG_WIDTH+EXP_WIDTH:0] a_i,
   input  logic [SIG_WIDTH+EXP_WIDTH:0] b_i,
   output logic [SIG_WIDTH+EXP_WIDTH:0] z_o
);
   localparam int N  = SIG_WIDTH + EXP_WIDTH + 1;
   localparam int W  = SIG_WIDTH + 5;
   localparam int EW = EXP_WIDTH + 2;
   localparam logic [EXP_WIDTH-1:0] EMAX   = '1;
   localparam logic signed [EW-1:0] EMAX_S = {2'b00, EMAX};

   logic                  sa, sb, sl, sub, sticky, found, rnd;
   logic                  a_zero, b_zero, a_spec, b_spec, a_nan, b_nan, swap;
   logic [EXP_WIDTH-1:0]  ea, eb, el, es, d;
   logic [SIG_WIDTH-1:0]  fa, fb, fl, fs, frac;
   logic [W-1:0]          ml, ms0, ms, sum;
   logic [W-2:0]          norm;
   logic [SIG_WIDTH+1:0]  mant;
   logic [EW-1:0]         lz;
   logic signed [EW-1:0]  en;

   // Denormals are flushed to zero; rounding is round-to-nearest-even.
   always_comb begin
      sa = a_i[N-1];  ea = a_i[N-2:SIG_WIDTH];  fa = a_i[SIG_WIDTH-1:0];
      sb = b_i[N-1];  eb = b_i[N-2:SIG_WIDTH];  fb = b_i[SIG_WIDTH-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_spec = (ea == EMAX);
      b_spec = (eb == EMAX);
      a_nan  = a_spec && (fa != '0);
      b_nan  = b_spec && (fb != '0);
      swap   = b_zero ? 1'b0 : (a_zero ? 1'b1 : ({eb, fb} > {ea, fa}));
      sub    = sa ^ sb;
      sl     = swap ? sb : sa;
      el     = swap ? eb : ea;
      es     = swap ? ea : eb;
      fl     = swap ? fb : fa;
      fs     = swap ? fa : fb;
      d      = el - es;
      ml     = {1'b0, 1'b1, fl, 3'b000};
      ms0    = {1'b0, 1'b1, fs, 3'b000};
      if (32'(d) >= W) begin
         ms     = '0;
         sticky = 1'b1;
      end else begin
         ms     = ms0 >> d;
         sticky = ((ms << d) != ms0);
      end
      ms[0] = ms[0] | sticky;
      sum   = sub ? (ml - ms) : (ml + ms);

      lz    = '0;
      found = 1'b0;
      for (int i = W - 2; i >= 0; i--) begin
         if (!found && sum[i]) begin
            lz    = EW'(W - 2 - i);
            found = 1'b1;
         end
      end

      en = $signed({2'b00, el});
      if (sum[W-1]) begin
         norm = {sum[W-1:2], sum[1] | sum[0]};
         en   = en + EW'(1);
      end else begin
         norm = sum[W-2:0] << lz;
         en   = en - $signed(lz);
      end
      rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant = {1'b0, norm[W-2:3]} + {{(SIG_WIDTH+1){1'b0}}, rnd};
      if (mant[SIG_WIDTH+1]) begin
         en   = en + EW'(1);
         frac = mant[SIG_WIDTH:1];
      end else begin
         frac = mant[SIG_WIDTH-1:0];
      end

      z_o = '0;
      if (a_spec || b_spec) begin
         if (IEEE_COMPLIANCE != 0 && (a_nan || b_nan || (a_spec && b_spec && sub)))
            z_o = {1'b0, EMAX, 1'b1, {(SIG_WIDTH-1){1'b0}}};
         else
            z_o = {a_spec ? sa : sb, EMAX, {SIG_WIDTH{1'b0}}};
      end else if (a_zero && b_zero) begin
         z_o = {sa & sb, {(N-1){1'b0}}};
      end else if (a_zero || b_zero) begin
         z_o = {sl, el, fl};
      end else if (sum == '0) begin
         z_o = '0;
      end else if (en[EW-1] || en == '0) begin
         z_o = {sl, {(N-1){1'b0}}};
      end else if (en >= EMAX_S) begin
         z_o = {sl, EMAX, {SIG_WIDTH{1'b0}}};
      end else begin
         z_o = {sl, en[EXP_WIDTH-1:0], frac};
      end
   end
endmodule

module fp_sq_accum #(
   parameter int SIG_WIDTH       = 23,
   parameter int EXP_WIDTH       = 8,
   parameter int IEEE_COMPLIANCE = 0,
   parameter int ADD_STAGES      = 5,
   parameter int CNT_WIDTH       = 12
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SIG_WIDTH+EXP_WIDTH:0] in_data,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic [SIG_WIDTH+EXP_WIDTH:0] sum_out,
   output logic                         sum_valid,
   output logic [CNT_WIDTH-1:0]         elem_cnt,
   output logic                         busy,
   output logic                         drop_err
);
   localparam int N  = SIG_WIDTH + EXP_WIDTH + 1;
   localparam int S  = ADD_STAGES;
   localparam int L  = ADD_STAGES;
   localparam int PW = (L > 1) ? $clog2(L) : 1;
   localparam int DW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_REDUCE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         lane_q [L];
   logic [N-1:0]         lane_d [L];
   logic [PW-1:0]        ptr_q, ptr_d, k_q, k_d;
   logic [DW-1:0]        drain_q, drain_d;
   logic                 red_issue_q, red_issue_d;
   logic [N-1:0]         acc_q, acc_d, sum_q, sum_d;
   logic                 sum_valid_q, sum_valid_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, elem_cnt_q, elem_cnt_d;

   logic                 pv_q [S];
   logic                 pr_q [S];
   logic [PW-1:0]        pt_q [S];
   logic [N-1:0]         pz_q [S];

   logic                 iss_v, iss_red;
   logic [PW-1:0]        iss_tag;
   logic [N-1:0]         op_a, op_b, add_z;
   logic                 po_v, po_red;
   logic [PW-1:0]        po_tag;
   logic [N-1:0]         po_z;

   fp_sq_accum_add #(
      .SIG_WIDTH       (SIG_WIDTH),
      .EXP_WIDTH       (EXP_WIDTH),
      .IEEE_COMPLIANCE (IEEE_COMPLIANCE)
   ) u_add (
      .a_i (op_a),
      .b_i (op_b),
      .z_o (add_z)
   );

   assign po_v   = pv_q[S-1];
   assign po_red = pr_q[S-1];
   assign po_tag = pt_q[S-1];
   assign po_z   = pz_q[S-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         ptr_q       <= '0;
         k_q         <= '0;
         drain_q     <= '0;
         red_issue_q <= 1'b0;
         acc_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         cnt_q       <= '0;
         elem_cnt_q  <= '0;
         for (int i = 0; i < L; i++) lane_q[i] <= '0;
         for (int i = 0; i < S; i++) pv_q[i] <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         k_q         <= k_d;
         drain_q     <= drain_d;
         red_issue_q <= red_issue_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         sum_valid_q <= sum_valid_d;
         cnt_q       <= cnt_d;
         elem_cnt_q  <= elem_cnt_d;
         lane_q      <= lane_d;
         pv_q[0]     <= iss_v;
         for (int i = 1; i < S; i++) pv_q[i] <= pv_q[i-1];
      end
   end

   // Adder retiming: payload needs no reset, validity is carried by pv_q.
   always_ff @(posedge clk) begin
      pr_q[0] <= iss_red;
      pt_q[0] <= iss_tag;
      pz_q[0] <= add_z;
      for (int i = 1; i < S; i++) begin
         pr_q[i] <= pr_q[i-1];
         pt_q[i] <= pt_q[i-1];
         pz_q[i] <= pz_q[i-1];
      end
   end

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      ptr_d       = ptr_q;
      k_d         = k_q;
      drain_d     = drain_q;
      red_issue_d = red_issue_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      sum_valid_d = 1'b0;
      cnt_d       = cnt_q;
      elem_cnt_d  = elem_cnt_q;
      iss_v       = 1'b0;
      iss_red     = 1'b0;
      iss_tag     = ptr_q;
      op_a        = in_data;
      op_b        = lane_q[ptr_q];

      if (po_v && !po_red) lane_d[po_tag] = po_z;

      case (state_q)
         ST_ACCUM: begin
            if (in_valid) begin
               iss_v = 1'b1;
               // Lane is being written back this very cycle: use the fresh sum.
               if (po_v && !po_red && po_tag == ptr_q) op_b = po_z;
               ptr_d = (ptr_q == PW'(L - 1)) ? '0 : ptr_q + PW'(1);
               if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
               if (in_last) begin
                  state_d = ST_DRAIN;
                  drain_d = DW'(S - 1);
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q != '0) begin
               drain_d = drain_q - DW'(1);
            end else if (L == 1) begin
               state_d     = ST_DONE;
               sum_d       = po_z;
               sum_valid_d = 1'b1;
               elem_cnt_d  = cnt_q;
            end else begin
               state_d     = ST_REDUCE;
               k_d         = PW'(1);
               red_issue_d = 1'b1;
            end
         end
         ST_REDUCE: begin
            if (red_issue_q) begin
               iss_v       = 1'b1;
               iss_red     = 1'b1;
               red_issue_d = 1'b0;
               op_a        = (k_q == PW'(1)) ? lane_q[0] : acc_q;
               op_b        = lane_q[k_q];
            end
            if (po_v && po_red) begin
               acc_d = po_z;
               if (k_q == PW'(L - 1)) begin
                  state_d     = ST_DONE;
                  sum_d       = po_z;
                  sum_valid_d = 1'b1;
                  elem_cnt_d  = cnt_q;
               end else begin
                  k_d         = k_q + PW'(1);
                  red_issue_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            for (int i = 0; i < L; i++) lane_d[i] = '0;
            ptr_d   = '0;
            cnt_d   = '0;
            state_d = ST_ACCUM;
         end
         default: state_d = ST_ACCUM;
      endcase
   end

`ifdef FP_SQ_ACCUM_DROP_ERR_EN
   logic drop_q;
   always_ff @(posedge clk) begin
      if (rst)
         drop_q <= 1'b0;
      else if (in_valid && state_q != ST_ACCUM)
         drop_q <= 1'b1;
   end
   assign drop_err = drop_q;
`else
   assign drop_err = 1'b0;
`endif

   assign sum_out   = sum_q;
   assign sum_valid = sum_valid_q;
   assign elem_cnt  = elem_cnt_q;
   assign busy      = (state_q != ST_ACCUM);
endmodule

`default_nettype wire

// File: tb/tb_fp_sq_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_sq_accum
// Purpose  : Scoreboard bench for fp_sq_accum (integer-valued FP elements).
// Revision : 1.0 - initial release
// ============================================================================

module tb_fp_sq_accum;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic [31:0] sum_out;
   logic        sum_valid;
   logic [11:0] elem_cnt;
   logic        busy;
   logic        drop_err;

   int cyc       = 0;
   int n_vec     = 0;
   int n_err     = 0;
   int model_sum = 0;
   int model_cnt = 0;

   typedef struct {
      logic [31:0] sum;
      int          cnt;
      int          due;
   } exp_t;
   exp_t sb_q[$];

`ifdef FP_SQ_ACCUM_DROP_ERR_EN
   localparam logic DROP_EXP = 1'b1;
`else
   localparam logic DROP_EXP = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_sq_accum dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .sum_out   (sum_out),
      .sum_valid (sum_valid),
      .elem_cnt  (elem_cnt),
      .busy      (busy),
      .drop_err  (drop_err)
   );

   // Exact single-precision encoding of a small non-negative integer.
   function automatic logic [31:0] int_to_fp(input int n);
      int          p;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 24; i++) if (n[i]) p = i;
      m = 32'(n) << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   task automatic send(input int val, input bit last, input int gap);
      exp_t e;
      in_data   = int_to_fp(val);
      in_valid  = 1'b1;
      in_last   = last;
      model_sum += val;
      model_cnt++;
      if (last) begin
         e.sum = int_to_fp(model_sum);
         e.cnt = model_cnt;
         e.due = cyc + 30;
         sb_q.push_back(e);
         model_sum = 0;
         model_cnt = 0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic wait_result(input string name);
      exp_t e;
      bit   seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (sum_valid) seen = 1'b1;
      end
      n_vec++;
      if (!seen || sb_q.size() == 0) begin
         n_err++;
         $display("FAIL %s_timeout: sum_valid seen=%0d queued=%0d, required seen=1 with an expectation",
                  name, seen, sb_q.size());
      end else begin
         e = sb_q.pop_front();
         n_vec++;
         if (sum_out !== e.sum) begin
            n_err++;
            $display("FAIL %s_sum: got %h, expected %h", name, sum_out, e.sum);
         end
         n_vec++;
         if (elem_cnt !== 12'(e.cnt)) begin
            n_err++;
            $display("FAIL %s_cnt: got %0d, expected %0d", name, elem_cnt, e.cnt);
         end
         n_vec++;
         if (cyc !== e.due) begin
            n_err++;
            $display("FAIL %s_latency: sum_valid at cycle %0d, expected %0d", name, cyc, e.due);
         end
         n_vec++;
         if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_busy_done: got %b, expected 1", name, busy);
         end
         @(negedge clk);
         n_vec++;
         if (sum_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after: sum_valid=%b busy=%b, expected 0 0", name, sum_valid, busy);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (sum_out !== 32'h0 || sum_valid !== 1'b0 || elem_cnt !== 12'd0) begin
         n_err++;
         $display("FAIL reset_outputs: sum=%h valid=%b cnt=%0d, expected 0 0 0", sum_out, sum_valid, elem_cnt);
      end
      n_vec++;
      if (busy !== 1'b0 || drop_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags: busy=%b drop_err=%b, expected 0 0", busy, drop_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_four_ones();
      for (int i = 0; i < 4; i++) send(1, i == 3, 0);
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL four_busy_start: got %b, expected 1", busy);
      end
      wait_result("four_ones");
   endtask

   task automatic test_single();
      send(3, 1'b1, 0);
      wait_result("single");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) send(2, i == 11, 0);
      wait_result("back_to_back");
   endtask

   task automatic test_gapped();
      for (int i = 0; i < 7; i++) send(1, i == 6, (i == 6) ? 0 : 2);
      wait_result("gapped");
   endtask

   task automatic test_random();
      for (int i = 0; i < 9; i++)
         send(int'($urandom_range(1, 20)), i == 8, (i == 8) ? 0 : int'($urandom_range(0, 3)));
      wait_result("random");
   endtask

   task automatic test_drop();
      send(1, 1'b0, 0);
      send(1, 1'b1, 0);
      repeat (4) begin @(posedge clk); #1; end
      in_data  = int_to_fp(1);
      in_valid = 1'b1;
      in_last  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_result("drop_vec");
      n_vec++;
      if (drop_err !== DROP_EXP) begin
         n_err++;
         $display("FAIL drop_err: got %b, expected %b", drop_err, DROP_EXP);
      end
      for (int i = 0; i < 3; i++) send(1, i == 2, 0);
      wait_result("after_drop");
   endtask

   task automatic test_rst_mid();
      bit stray = 1'b0;
      for (int i = 0; i < 3; i++) send(1, 1'b0, 0);
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst       = 1'b0;
      model_sum = 0;
      model_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sum_valid) stray = 1'b1;
      end
      n_vec++;
      if (stray !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_stray: sum_valid seen=%b, expected 0", stray);
      end
      n_vec++;
      if (sum_out !== 32'h0 || elem_cnt !== 12'd0 || drop_err !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_clear: sum=%h cnt=%0d drop=%b, expected 0 0 0", sum_out, elem_cnt, drop_err);
      end
      @(posedge clk); #1;
      send(1, 1'b0, 0);
      send(1, 1'b1, 0);
      wait_result("rst_mid");
   endtask

   initial begin
      test_reset();
      test_four_ones();
      test_single();
      test_back_to_back();
      test_gapped();
      test_random();
      test_drop();
      test_rst_mid();
      n_vec++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_leftover: %0d entries, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
